// File: rtl/hsv_pkg.sv
// Shared types and constants for the HSV colour bounding-box stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hsv_pkg;

    typedef struct packed {
        logic [7:0] hue;
        logic [7:0] sat;
        logic [7:0] val;
    } hsv_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VIDEO = 2'd1,
        ST_OTHER = 2'd2
    } bbox_state_t;

    localparam hsv_t       HIGHLIGHT_HSV = '{hue: 8'd0, sat: 8'hFF, val: 8'hFF};
    localparam logic [7:0] HUE_MAX       = 8'd179;
    localparam logic [3:0] PKT_VIDEO     = 4'h0;

    localparam int POS_W = 11;
    localparam int CNT_W = 19;

endpackage

// File: rtl/hsv_band_match.sv
// Combinational HSV colour-band classifier; hue_lo > hue_hi selects the wrap band (reds).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller qualifies the result with its own handshake.
import hsv_pkg::*;

module hsv_band_match (
    input  hsv_t       pix,
    input  logic [7:0] hue_lo,
    input  logic [7:0] hue_hi,
    input  logic [7:0] sat_min,
    input  logic [7:0] val_min,
    output logic       match
);

    logic hue_ok;

    // Hue test is a plain range, or its complement-style union when the band wraps past HUE_MAX.
    always_comb begin
        hue_ok = 1'b0;
        if (hue_lo <= hue_hi)
            hue_ok = (pix.hue >= hue_lo) && (pix.hue <= hue_hi);
        else
            hue_ok = (pix.hue >= hue_lo) || (pix.hue <= hue_hi);
        match = hue_ok && (pix.sat >= sat_min) && (pix.val >= val_min);
    end

endmodule

// File: rtl/hsv_colour_bbox.sv
// Classifies HSV pixels against a band, accumulates per-frame bbox/count; optional HSV_BBOX_HIGHLIGHT_EN recolours hits.
// Latency: 1 cycle through a single data/sop/eop/valid output register; bbox results 1 cycle after eop.
// Backpressure: sink_ready = ~source_valid | source_ready; output holds while stalled, no beat lost.
import hsv_pkg::*;

module hsv_colour_bbox #(
    parameter logic [10:0] IMAGE_W = 11'd640,
    parameter logic [10:0] IMAGE_H = 11'd480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      sink_data,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    output logic             sink_ready,
    output logic [23:0]      source_data,
    output logic             source_valid,
    output logic             source_sop,
    output logic             source_eop,
    input  logic             source_ready,
    input  logic [7:0]       hue_lo,
    input  logic [7:0]       hue_hi,
    input  logic [7:0]       sat_min,
    input  logic [7:0]       val_min,
    output logic [POS_W-1:0] bbox_x_min,
    output logic [POS_W-1:0] bbox_x_max,
    output logic [POS_W-1:0] bbox_y_min,
    output logic [POS_W-1:0] bbox_y_max,
    output logic [CNT_W-1:0] bbox_count,
    output logic             bbox_empty,
    output logic             bbox_valid
);

    bbox_state_t      state, state_nxt;
    hsv_t             pix;
    hsv_t             out_dat;
    logic             acc, hdr_video, video_hdr, band_hit, is_pix, pix_hit, latch;
    logic [POS_W-1:0] x, y;
    logic             frame_full;
    logic [POS_W-1:0] x_min, x_max, y_min, y_max;
    logic [POS_W-1:0] x_min_n, x_max_n, y_min_n, y_max_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             any, any_n;

    assign pix        = sink_data;
    assign sink_ready = ~source_valid | source_ready;
    assign acc        = sink_valid & sink_ready;
    assign hdr_video  = (sink_data[3:0] == PKT_VIDEO);
    assign video_hdr  = acc & sink_sop & hdr_video;
    // Only pixels inside the W*H raster of a live video frame are classified.
    assign is_pix     = acc & ~sink_sop & (state == ST_VIDEO) & ~frame_full;
    assign pix_hit    = is_pix & band_hit;
    // eop closes a video frame; a video header that is also eop closes an empty frame.
    assign latch      = acc & sink_eop & (sink_sop ? hdr_video : (state == ST_VIDEO));

    hsv_band_match u_match (
        .pix     (pix),
        .hue_lo  (hue_lo),
        .hue_hi  (hue_hi),
        .sat_min (sat_min),
        .val_min (val_min),
        .match   (band_hit)
    );

`ifdef HSV_BBOX_HIGHLIGHT_EN
    assign out_dat = pix_hit ? HIGHLIGHT_HSV : pix;
`else
    assign out_dat = pix;
`endif

    // Packet state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: sop always re-decides the packet type, eop always ends the packet.
    always_comb begin
        state_nxt = state;
        if (acc) begin
            if (sink_sop)
                state_nxt = hdr_video ? ST_VIDEO : ST_OTHER;
            if (sink_eop)
                state_nxt = ST_IDLE;
        end
    end

    // Raster position; x wraps per line, y stops at the last line and frame_full blocks overflow pixels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            frame_full <= 1'b0;
        end else if (video_hdr) begin
            x          <= '0;
            y          <= '0;
            frame_full <= 1'b0;
        end else if (is_pix) begin
            if (x == IMAGE_W - 11'd1) begin
                x <= '0;
                if (y == IMAGE_H - 11'd1) frame_full <= 1'b1;
                else                      y          <= y + 11'd1;
            end else begin
                x <= x + 11'd1;
            end
        end
    end

    // Accumulator next values include the current beat so the latch sees the eop pixel too.
    always_comb begin
        x_min_n = x_min;
        x_max_n = x_max;
        y_min_n = y_min;
        y_max_n = y_max;
        cnt_n   = cnt;
        any_n   = any;
        if (video_hdr) begin
            x_min_n = '1;
            x_max_n = '0;
            y_min_n = '1;
            y_max_n = '0;
            cnt_n   = '0;
            any_n   = 1'b0;
        end
        if (pix_hit) begin
            if (x < x_min_n) x_min_n = x;
            if (x > x_max_n) x_max_n = x;
            if (y < y_min_n) y_min_n = y;
            if (y > y_max_n) y_max_n = y;
            if (cnt_n != '1) cnt_n = cnt_n + 19'd1;
            any_n = 1'b1;
        end
    end

    // Running accumulators for the frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_min <= '1;
            x_max <= '0;
            y_min <= '1;
            y_max <= '0;
            cnt   <= '0;
            any   <= 1'b0;
        end else begin
            x_min <= x_min_n;
            x_max <= x_max_n;
            y_min <= y_min_n;
            y_max <= y_max_n;
            cnt   <= cnt_n;
            any   <= any_n;
        end
    end

    // Latched per-frame results; an empty frame reports a zero box.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bbox_x_min <= '0;
            bbox_x_max <= '0;
            bbox_y_min <= '0;
            bbox_y_max <= '0;
            bbox_count <= '0;
            bbox_empty <= 1'b1;
            bbox_valid <= 1'b0;
        end else begin
            bbox_valid <= latch;
            if (latch) begin
                bbox_x_min <= any_n ? x_min_n : '0;
                bbox_x_max <= any_n ? x_max_n : '0;
                bbox_y_min <= any_n ? y_min_n : '0;
                bbox_y_max <= any_n ? y_max_n : '0;
                bbox_count <= cnt_n;
                bbox_empty <= ~any_n;
            end
        end
    end

    // Single output register stage; loads whenever the slot is free or being drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            source_valid <= 1'b0;
            source_data  <= '0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
        end else if (sink_ready) begin
            source_valid <= sink_valid;
            if (sink_valid) begin
                source_data <= out_dat;
                source_sop  <= sink_sop;
                source_eop  <= sink_eop;
            end
        end
    end

endmodule

// File: doc/hsv_colour_bbox.md
# hsv_colour_bbox

Stream stage directly downstream of the RGB-to-HSV converter. It consumes the 24-bit {hue, saturation, value} Avalon-ST video stream and classifies each pixel against a programmable HSV colour band. Per frame, it accumulates the bounding box and pixel count of matching pixels. The stream is forwarded through one registered, backpressure-aware stage; bounding-box results are latched at end of frame for the control/beacon logic.

## Interface
- IMAGE_W, 11'd640, pixels per line
- IMAGE_H, 11'd480, lines per frame
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sink_data  in  24  {hue[23:16], sat[15:8], val[7:0]}; hue range 0..179
- sink_valid / sink_sop / sink_eop  in  1  Avalon-ST sink qualifiers
- sink_ready  out  1  sink backpressure
- source_data  out  24  forwarded beat
- source_valid / source_sop / source_eop  out  1  source qualifiers
- source_ready  in  1  downstream backpressure
- hue_lo, hue_hi  in  8  hue band bounds, inclusive
- sat_min, val_min  in  8  minimum saturation and minimum value, inclusive
- bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max  out  11  latched box
- bbox_count  out  19  latched count of matching pixels
- bbox_empty  out  1  latched; no match in the frame
- bbox_valid  out  1  one-cycle pulse when the latched results update

## Operation
- Accept: acc = sink_valid & sink_ready.
- States: IDLE, VIDEO, OTHER.
  - Any accepted sop beat is a header. data[3:0]==0 enters VIDEO; any other value enters OTHER.
  - A sop beat overrides the current state. The aborted frame is not latched.
  - An accepted eop beat in VIDEO latches results and returns to IDLE.
  - An accepted eop beat in OTHER returns to IDLE.
  - Non-sop beats in IDLE are forwarded but not classified.
- Pixel position: x, y counters cleared on the video header.
  - x increments per accepted pixel and wraps at IMAGE_W-1 to 0, incrementing y.
  - y saturates at IMAGE_H-1. Pixels after W*H are forwarded but not classified.
- Match: (hue_lo<=hue_hi ? hue_lo<=h<=hue_hi : h>=hue_lo | h<=hue_hi) & s>=sat_min & v>=val_min.
  - The hue_lo>hue_hi case is the wrap band for red.
- Accumulators are reset on the video header: min=all-ones, max=0, count=0, any=0.
  - On a match: min/max updated, count+1, any=1.
  - The count saturates at 2^19-1.
- Latch: results include the current beat if it matches. bbox_empty=~any.
  - If empty, the box outputs are 0.
- Thresholds are sampled on every accepted beat. Changing them mid-frame is permitted and takes effect on the next beat.

## Timing
- Latency: 1 cycle, through a single output register holding data, sop, eop and valid.
- sink_ready = ~source_valid | source_ready, combinational.
- No beat is lost or duplicated under any valid/ready pattern.
- Source outputs hold stable while source_valid & ~source_ready.
- bbox_valid pulses on the cycle after the eop beat is accepted.
  - The latched outputs change on that same edge and hold until the next latch.
- A video header carrying sop&eop on the same beat latches count=0, empty=1.
- Reset, asynchronous and effective at any time, including mid-frame:
  - state=IDLE, source_valid=0, source_sop/eop=0, source_data=0.
  - All bbox outputs 0, bbox_empty=1, bbox_valid=0.
  - After reset, the block ignores beats until the next sop.

## Configuration
- HSV_BBOX_HIGHLIGHT_EN defined: matching pixels in VIDEO are replaced on the source by HIGHLIGHT_HSV, a package constant {8'd0, 8'hFF, 8'hFF}. Headers and non-matching pixels pass unchanged.
- Undefined: source_data is always the unmodified sink_data. Statistics are identical in both builds.

## Structure
- Package hsv_pkg: hsv_t packed struct {hue, sat, val}; state enum; HIGHLIGHT_HSV; HUE_MAX=179; PKT_VIDEO=4'h0.
- Sub-module hsv_band_match: purely combinational match function. It is unit-testable, including the wrap case.
- Top holds the FSM, counters, accumulators and output register.

## Test plan
Bench parameters: IMAGE_W=8, IMAGE_H=4.
- Band 20..40, sat/val min 100; single match {30,200,200} at x=3, y=2 -> bbox 3,3,2,2, count 1, empty 0, bbox_valid one cycle after eop.
- Wrap band hue_lo=170, hue_hi=10; hues 175, 5, 90 at x=0, 1, 2 on line 0 -> count 2, x 0..1, y 0..0.
- source_ready toggled 1010… through a full frame -> output beat sequence equals input beat sequence, sop/eop aligned, no drops.
- Non-video header (data[3:0]=4'hF) with matching-looking beats -> forwarded unchanged, no bbox_valid.
- Reset asserted mid-frame after 5 pixels, then a new frame with no matches -> outputs at reset values, next latch gives empty=1, count=0.
- With HSV_BBOX_HIGHLIGHT_EN: matching pixel emerges as 24'h00FFFF; a non-match emerges unchanged.
